// File: rtl/lvds_tx_pkg.sv
// Shared types, constant words and the pixel-to-lane bit mapping for the 7:1 LVDS transmit path.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package lvds_tx_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        TRAIN     = 2'd1,
        RUN       = 2'd2
    } tx_state_t;

    // Clock lane carries a 4-high/3-low pattern; the same word doubles as the alignment pattern.
    localparam logic [6:0] CLK_PATTERN   = 7'b1100011;
    localparam logic [6:0] TRAIN_PATTERN = 7'b1100011;

    // Returns {lane3, lane2, lane1, lane0}; bit 6 of each lane is serialized first.
    // format 0 = VESA (LSBs on lanes 0-2), 1 = JEIDA (MSBs on lanes 0-2, LSBs on lane 3).
    function automatic logic [27:0] map_pixel(
        input logic        format,
        input logic [23:0] rgb,
        input logic        hs,
        input logic        vs,
        input logic        de
    );
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [6:0] l0;
        logic [6:0] l1;
        logic [6:0] l2;
        logic [6:0] l3;
        r = rgb[23:16];
        g = rgb[15:8];
        b = rgb[7:0];
        if (format) begin
            l0 = {g[2], r[7:2]};
            l1 = {b[3:2], g[7:3]};
            l2 = {de, vs, hs, b[7:4]};
            l3 = {1'b0, b[1:0], g[1:0], r[1:0]};
        end else begin
            l0 = {g[0], r[5:0]};
            l1 = {b[1:0], g[5:1]};
            l2 = {de, vs, hs, b[5:2]};
            l3 = {1'b0, b[7:6], g[7:6], r[7:6]};
        end
        return {l3, l2, l1, l0};
    endfunction

endpackage

// File: rtl/lvds_tx_lock_sync.sv
// Synchronizes the asynchronous PLL lock and requires LOCK_HOLD consecutive locked cycles.
// Latency: 2 cycles of synchronizer, then lock_ok pulses after LOCK_HOLD locked cycles.
// Backpressure: none; hold_en low (link not waiting for lock) keeps the counter cleared.
module lvds_tx_lock_sync #(
    parameter int unsigned LOCK_HOLD = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pll_lock,
    input  logic hold_en,
    output logic lock_s,
    output logic lock_ok
);
    localparam int unsigned CW = (LOCK_HOLD > 1) ? $clog2(LOCK_HOLD + 1) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(LOCK_HOLD - 1);

    logic          lock_meta;
    logic [CW-1:0] hold_cnt;

    // Two-flop synchronizer for the PLL lock level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // Consecutive-lock counter; any drop or leaving the wait state restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
        end else if (!lock_s || !hold_en || hold_cnt == HOLD_LAST) begin
            hold_cnt <= '0;
        end else begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end

    assign lock_ok = hold_en && lock_s && (hold_cnt == HOLD_LAST);

endmodule

// File: rtl/lvds_7to1_tx_mapper.sv
// Pixel-clock front end of the 7:1 LVDS transmitter: lock gating, training, pixel-to-lane mapping.
// Latency: 1 cycle from accepted pixel to lane outputs; all outputs registered.
// Backpressure: s_ready is high only in RUN; idle cycles there send blanking words.
module lvds_7to1_tx_mapper
    import lvds_tx_pkg::*;
#(
    parameter int unsigned FORMAT       = 0,
    parameter int unsigned LOCK_HOLD    = 1024,
    parameter int unsigned TRAIN_CYCLES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pll_lock,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [23:0] s_rgb,
    input  logic        s_hs,
    input  logic        s_vs,
    input  logic        s_de,
    output logic [6:0]  tx_lane0,
    output logic [6:0]  tx_lane1,
    output logic [6:0]  tx_lane2,
    output logic [6:0]  tx_lane3,
    output logic [6:0]  tx_clk_lane,
    output logic        link_up,
    output logic [15:0] underflow_cnt
);
    localparam logic FMT_JEIDA = (FORMAT != 0);
    localparam int unsigned TW = (TRAIN_CYCLES > 1) ? $clog2(TRAIN_CYCLES + 1) : 1;
    localparam logic [TW-1:0] TRAIN_LAST = TW'(TRAIN_CYCLES - 1);

    tx_state_t     state_q;
    tx_state_t     state_d;
    logic [TW-1:0] train_cnt;
    logic          lock_s;
    logic          lock_ok;
    logic          accept;
    logic          last_hs;
    logic          last_vs;
    logic          last_de;
    logic [27:0]   lane_word_d;

    lvds_tx_lock_sync #(
        .LOCK_HOLD (LOCK_HOLD)
    ) u_lock_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .pll_lock (pll_lock),
        .hold_en  (state_q == WAIT_LOCK),
        .lock_s   (lock_s),
        .lock_ok  (lock_ok)
    );

    // s_ready mirrors RUN, so this is exactly a RUN-state handshake.
    assign accept = s_valid && s_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_LOCK;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: lock loss from TRAIN or RUN wins over everything else.
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_LOCK: if (lock_ok) state_d = TRAIN;
            TRAIN: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (train_cnt == TRAIN_LAST) begin
                    state_d = RUN;
                end
            end
            RUN:       if (!lock_s) state_d = WAIT_LOCK;
            default:   state_d = WAIT_LOCK;
        endcase
    end

    // Training length counter, running only while staying in TRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            train_cnt <= '0;
        end else if (state_q == TRAIN && state_d == TRAIN) begin
            train_cnt <= train_cnt + 1'b1;
        end else begin
            train_cnt <= '0;
        end
    end

    // Status flags and the sync/DE history used for blanking and underflow detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready     <= 1'b0;
            link_up     <= 1'b0;
            tx_clk_lane <= '0;
            last_hs     <= 1'b0;
            last_vs     <= 1'b0;
            last_de     <= 1'b0;
        end else begin
            s_ready     <= (state_d == RUN);
            link_up     <= (state_d == RUN);
            tx_clk_lane <= CLK_PATTERN;
            if (accept) begin
                last_hs <= s_hs;
                last_vs <= s_vs;
            end
            if (state_d != RUN) begin
                last_de <= 1'b0;
            end else if (accept) begin
                last_de <= s_de;
            end
        end
    end

    // Lane word for the coming cycle, chosen from the state being entered.
    always_comb begin
        lane_word_d = '0;
        case (state_d)
            TRAIN: lane_word_d = {4{TRAIN_PATTERN}};
            RUN: begin
                if (accept) begin
                    lane_word_d = map_pixel(FMT_JEIDA, s_rgb, s_hs, s_vs, s_de);
                end else begin
                    lane_word_d = map_pixel(FMT_JEIDA, 24'h0, last_hs, last_vs, 1'b0);
                end
            end
            default: lane_word_d = '0;
        endcase
    end

    // Lane output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_lane0 <= '0;
            tx_lane1 <= '0;
            tx_lane2 <= '0;
            tx_lane3 <= '0;
        end else begin
            tx_lane0 <= lane_word_d[6:0];
            tx_lane1 <= lane_word_d[13:7];
            tx_lane2 <= lane_word_d[20:14];
            tx_lane3 <= lane_word_d[27:21];
        end
    end

    // Mid-line starvation counter: idle RUN cycle while the last beat was active video.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underflow_cnt <= '0;
        end else if (state_q == RUN && !s_valid && last_de && underflow_cnt != 16'hFFFF) begin
            underflow_cnt <= underflow_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_lvds_7to1_tx_mapper.sv
module tb_lvds_7to1_tx_mapper;

    logic        clk;
    logic        rst_n;
    logic        pll_lock;
    logic        s_valid;
    logic [23:0] s_rgb;
    logic        s_hs;
    logic        s_vs;
    logic        s_de;

    logic        v_ready, j_ready;
    logic [6:0]  v_l0, v_l1, v_l2, v_l3, v_clk;
    logic [6:0]  j_l0, j_l1, j_l2, j_l3, j_clk;
    logic        v_up, j_up;
    logic [15:0] v_ufl, j_ufl;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [6:0] TRN = 7'b1100011;

    lvds_7to1_tx_mapper #(.FORMAT(0), .LOCK_HOLD(16), .TRAIN_CYCLES(8)) u_vesa (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
        .s_valid(s_valid), .s_ready(v_ready), .s_rgb(s_rgb),
        .s_hs(s_hs), .s_vs(s_vs), .s_de(s_de),
        .tx_lane0(v_l0), .tx_lane1(v_l1), .tx_lane2(v_l2), .tx_lane3(v_l3),
        .tx_clk_lane(v_clk), .link_up(v_up), .underflow_cnt(v_ufl)
    );

    lvds_7to1_tx_mapper #(.FORMAT(1), .LOCK_HOLD(16), .TRAIN_CYCLES(8)) u_jeida (
        .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
        .s_valid(s_valid), .s_ready(j_ready), .s_rgb(s_rgb),
        .s_hs(s_hs), .s_vs(s_vs), .s_de(s_de),
        .tx_lane0(j_l0), .tx_lane1(j_l1), .tx_lane2(j_l2), .tx_lane3(j_l3),
        .tx_clk_lane(j_clk), .link_up(j_up), .underflow_cnt(j_ufl)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [23:0] rgb, input logic hs, input logic vs, input logic de);
        s_valid = v;
        s_rgb   = rgb;
        s_hs    = hs;
        s_vs    = vs;
        s_de    = de;
    endtask

    initial begin
        clk      = 1'b0;
        rst_n    = 1'b0;
        pll_lock = 1'b1;
        drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);

        #2;
        check_eq("rst_lane0", {25'd0, v_l0}, 32'd0);
        check_eq("rst_lane2", {25'd0, v_l2}, 32'd0);
        check_eq("rst_clk_lane", {25'd0, v_clk}, 32'd0);
        check_eq("rst_ready", {31'd0, v_ready}, 32'd0);
        check_eq("rst_link_up", {31'd0, v_up}, 32'd0);
        check_eq("rst_underflow", {16'd0, v_ufl}, 32'd0);

        #10;
        rst_n = 1'b1;

        // Bring-up: 2 sync cycles + 16 hold cycles, then 8 training cycles.
        repeat (17) tick();
        check_eq("wait_lane0_e17", {25'd0, v_l0}, 32'd0);
        check_eq("wait_link_e17", {31'd0, v_up}, 32'd0);
        check_eq("clk_lane_pattern", {25'd0, v_clk}, {25'd0, TRN});
        tick();
        check_eq("train_v_lane0", {25'd0, v_l0}, {25'd0, TRN});
        check_eq("train_v_lane3", {25'd0, v_l3}, {25'd0, TRN});
        check_eq("train_j_lane1", {25'd0, j_l1}, {25'd0, TRN});
        check_eq("train_j_lane2", {25'd0, j_l2}, {25'd0, TRN});
        repeat (7) tick();
        check_eq("train_last_lane2", {25'd0, v_l2}, {25'd0, TRN});
        check_eq("train_last_link", {31'd0, v_up}, 32'd0);
        check_eq("train_last_ready", {31'd0, v_ready}, 32'd0);
        tick();
        check_eq("run_link_up_v", {31'd0, v_up}, 32'd1);
        check_eq("run_ready_v", {31'd0, v_ready}, 32'd1);
        check_eq("run_link_up_j", {31'd0, j_up}, 32'd1);

        // Red pixel, HS=1, DE=1.
        drive(1'b1, 24'hFF0000, 1'b1, 1'b0, 1'b1);
        tick();
        check_eq("vesa_red_l0", {25'd0, v_l0}, 32'b0111111);
        check_eq("vesa_red_l1", {25'd0, v_l1}, 32'd0);
        check_eq("vesa_red_l2", {25'd0, v_l2}, 32'b1010000);
        check_eq("vesa_red_l3", {25'd0, v_l3}, 32'b0000011);
        check_eq("jeida_red_l0", {25'd0, j_l0}, 32'b0111111);
        check_eq("jeida_red_l1", {25'd0, j_l1}, 32'd0);
        check_eq("jeida_red_l2", {25'd0, j_l2}, 32'b1010000);
        check_eq("jeida_red_l3", {25'd0, j_l3}, 32'b0000011);

        // Blue LSBs distinguish the two mappings on lane3 and lane1.
        drive(1'b1, 24'h000003, 1'b1, 1'b0, 1'b1);
        tick();
        check_eq("vesa_b3_l3", {25'd0, v_l3}, 32'd0);
        check_eq("jeida_b3_l3", {25'd0, j_l3}, 32'b0110000);
        check_eq("vesa_b3_l1", {25'd0, v_l1}, 32'b1100000);
        check_eq("jeida_b3_l1", {25'd0, j_l1}, 32'd0);
        check_eq("vesa_b3_l0", {25'd0, v_l0}, 32'd0);

        // Starve mid-line for 5 cycles.
        drive(1'b0, 24'hABCDEF, 1'b0, 1'b1, 1'b1);
        repeat (5) tick();
        check_eq("underflow_5", {16'd0, v_ufl}, 32'd5);
        check_eq("blank_v_l2", {25'd0, v_l2}, 32'b0010000);
        check_eq("blank_v_l0", {25'd0, v_l0}, 32'd0);
        check_eq("blank_j_l2", {25'd0, j_l2}, 32'b0010000);

        // DE=0 beat, then idle: count frozen, VS held.
        drive(1'b1, 24'h0, 1'b0, 1'b1, 1'b0);
        tick();
        check_eq("de0_beat_l2", {25'd0, v_l2}, 32'b0100000);
        drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        check_eq("underflow_hold", {16'd0, v_ufl}, 32'd5);
        check_eq("blank_vs_held", {25'd0, v_l2}, 32'b0100000);

        // One-cycle lock drop during RUN.
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        tick();
        check_eq("loss_ready_still", {31'd0, v_ready}, 32'd1);
        drive(1'b1, 24'hFF0000, 1'b1, 1'b0, 1'b1);
        tick();
        check_eq("loss_ready", {31'd0, v_ready}, 32'd0);
        check_eq("loss_link", {31'd0, v_up}, 32'd0);
        check_eq("loss_lane0_zero", {25'd0, v_l0}, 32'd0);
        check_eq("loss_lane2_zero", {25'd0, j_l2}, 32'd0);
        drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        repeat (15) tick();
        check_eq("relock_wait_lane0", {25'd0, v_l0}, 32'd0);
        tick();
        check_eq("relock_train_lane0", {25'd0, v_l0}, {25'd0, TRN});
        repeat (7) tick();
        check_eq("relock_link_low", {31'd0, v_up}, 32'd0);
        tick();
        check_eq("relock_link_up", {31'd0, v_up}, 32'd1);
        check_eq("relock_ready_j", {31'd0, j_ready}, 32'd1);
        check_eq("relock_underflow", {16'd0, v_ufl}, 32'd5);

        // Fresh DE=1 beat then one idle cycle counts once more.
        drive(1'b1, 24'h123456, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("underflow_6", {16'd0, v_ufl}, 32'd6);

        // Asynchronous reset between edges.
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst_lane0", {25'd0, v_l0}, 32'd0);
        check_eq("arst_lane2", {25'd0, v_l2}, 32'd0);
        check_eq("arst_clk_lane", {25'd0, v_clk}, 32'd0);
        check_eq("arst_ready", {31'd0, v_ready}, 32'd0);
        check_eq("arst_link", {31'd0, v_up}, 32'd0);
        check_eq("arst_underflow", {16'd0, v_ufl}, 32'd0);
        check_eq("arst_underflow_j", {16'd0, j_ufl}, 32'd0);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lvds_7to1_tx_mapper.md
# lvds_7to1_tx_mapper

Pixel-clock-domain front end of the 7:1 LVDS transmit path, the sending counterpart of the 7:1 receive chain. It accepts RGB888 pixels with sync and data-enable through a valid/ready handshake and gates link bring-up on PLL lock. It emits a training pattern, then maps each pixel onto four 7-bit data-lane words plus the constant clock-lane word, ready for the downstream 7:1 serializers.

## Interface
- `FORMAT`, default 0: bit mapping, 0 = VESA, 1 = JEIDA.
- `LOCK_HOLD`, default 1024: consecutive synchronized-lock cycles required before training starts.
- `TRAIN_CYCLES`, default 256: cycles of training pattern before streaming.
- `clk`  in  1  pixel clock; the only clock in the block.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `pll_lock`  in  1  transmit PLL lock; asynchronous to `clk`.
- `s_valid`  in  1  pixel valid.
- `s_ready`  out  1  pixel accepted when `s_valid && s_ready`.
- `s_rgb`  in  24  pixel data as {R[7:0], G[7:0], B[7:0]}.
- `s_hs`, `s_vs`, `s_de`  in  1 each  sync and data enable, qualified by `s_valid`.
- `tx_lane0` … `tx_lane3`  out  7 each  data-lane words; bit 6 is serialized first.
- `tx_clk_lane`  out  7  clock-lane word.
- `link_up`  out  1  high while in RUN.
- `underflow_cnt`  out  16  saturating count of mid-line starvation cycles.

## Operation
- `pll_lock` passes through a 2-FF synchronizer; `lock_s` is the synchronized value.
- State machine states: WAIT_LOCK, TRAIN, RUN. Reset state is WAIT_LOCK.
- WAIT_LOCK:
  - Counts consecutive cycles with `lock_s=1`. Any `lock_s=0` clears the count.
  - When the count reaches `LOCK_HOLD-1`, go to TRAIN and clear the counter.
- TRAIN:
  - All four data lanes output 7'b1100011, which the receiver uses for word alignment.
  - After `TRAIN_CYCLES` cycles, go to RUN.
- RUN:
  - `s_ready=1`.
  - On an accepted beat, the lanes carry the mapped pixel.
  - On a cycle with `s_valid=0`, the lanes carry a blanking word: RGB=0, DE=0, HS/VS held at the last accepted values.
- `lock_s=0` in TRAIN or RUN: go to WAIT_LOCK on the next edge with the counter cleared. From that edge, lanes output all-zero, `s_ready=0` and `link_up=0`.
- Lane mapping, listed bit6..bit0, RES=0:
  - VESA lane0: G0 R5 R4 R3 R2 R1 R0
  - VESA lane1: B1 B0 G5 G4 G3 G2 G1
  - VESA lane2: DE VS HS B5 B4 B3 B2
  - VESA lane3: RES B7 B6 G7 G6 R7 R6
  - JEIDA lane0: G2 R7 R6 R5 R4 R3 R2
  - JEIDA lane1: B3 B2 G7 G6 G5 G4 G3
  - JEIDA lane2: DE VS HS B7 B6 B5 B4
  - JEIDA lane3: RES B1 B0 G1 G0 R1 R0
- `tx_clk_lane` is 7'b1100011 in every state once out of reset.
- `underflow_cnt`:
  - Increments in RUN on each cycle with `s_valid=0` while the last accepted beat had DE=1.
  - Saturates at 16'hFFFF and clears only on reset.
  - The "last DE" flag is cleared on exit from RUN.

## Timing
- Reset values:
  - all lane outputs and `tx_clk_lane` 0
  - `s_ready`, `link_up` 0
  - `underflow_cnt` 0
  - synchronized lock value and last HS/VS/DE all 0
- Lock latency: `pll_lock` rising to TRAIN entry takes 2 synchronizer cycles + `LOCK_HOLD` cycles.
- `s_ready` and `link_up` are registered and assert on the first RUN cycle.
- Data latency: a pixel accepted on edge N appears on the lane outputs after edge N (1 cycle); all outputs are registered.
- Simultaneous lock loss and accepted beat: the beat is accepted, but the next lane output is zeros, because lock loss has priority.
- Lock bouncing in WAIT_LOCK restarts the hold count with no output change.
- Asserting `rst_n` low mid-frame forces every output to its reset value immediately (asynchronous).

## Structure
- Package `lvds_tx_pkg` holds:
  - the state enum
  - `CLK_PATTERN`, `TRAIN_PATTERN` (both 7'b1100011)
  - a function `map_pixel(format, rgb, hs, vs, de)` returning 28 bits {lane3, lane2, lane1, lane0}
- One sub-module, `lvds_tx_lock_sync`: the 2-FF synchronizer plus the `LOCK_HOLD` stability counter. It outputs a one-cycle pulse `lock_ok` and a level `lock_s`.

## Test plan
- Reset then lock, with `LOCK_HOLD=16`, `TRAIN_CYCLES=8` and `pll_lock` high at t0:
  - TRAIN is entered 18 cycles later; lanes read 7'b1100011 for 8 cycles.
  - `link_up` and `s_ready` go high on the next cycle.
- VESA mapping: accept `s_rgb=24'hFF0000`, HS=1, VS=0, DE=1. One cycle later:
  - lane0 = 7'b0111111
  - lane1 = 0
  - lane2 = 7'b1010000
  - lane3 = 7'b0000011
- JEIDA mapping of the same pixel:
  - lane0 = 7'b0111111
  - lane1 = 0
  - lane2 = 7'b1010000
  - lane3 = 7'b0000011
  - Then repeat with `s_rgb=24'h000003` and expect lane3 = 7'b0000000 for VESA vs 7'b0110000 for JEIDA.
- Underflow: accept a DE=1 pixel, then hold `s_valid=0` for 5 cycles:
  - `underflow_cnt` = 5
  - lanes show DE=0 with HS held
  - then accept a DE=0 beat followed by idle: the count is unchanged.
- Lock loss: drop `pll_lock` for 1 cycle during RUN:
  - 3 cycles later `s_ready=0` and lanes are zero
  - the full `LOCK_HOLD` + `TRAIN_CYCLES` sequence repeats before `link_up` returns.
- Asynchronous reset mid-stream: pull `rst_n` low between edges. All outputs are 0 immediately and `underflow_cnt` = 0.
